// File: rtl/gshare_branch_predictor_pkg.sv
// Shared helpers for the gshare predictor family: GHR folding, counter
// saturation and the counter reset value. Widths are passed as arguments
// so the same functions serve every instance parameterisation.
package bp_pkg;

    // Widest GHR / index / counter any instance may use.
    localparam int MAX_W = 32;

    typedef logic [MAX_W-1:0] word_t;

    // XOR successive idx_w-bit chunks of the low ghr_w bits, LSB chunk first.
    // A partial top chunk is implicitly zero-extended.
    function automatic word_t fold(input word_t ghr, input int ghr_w, input int idx_w);
        word_t res;
        int    b;
        res = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < ghr_w) begin
                b = i % idx_w;
                res[b[4:0]] = res[b[4:0]] ^ ghr[i];
            end
        end
        return res;
    endfunction

    // Increment, holding at the all-ones value of a w-bit counter.
    function automatic word_t sat_inc(input word_t v, input int w);
        word_t max_v;
        max_v = (word_t'(1) << w) - word_t'(1);
        return (v >= max_v) ? max_v : v + word_t'(1);
    endfunction

    // Decrement, holding at zero.
    function automatic word_t sat_dec(input word_t v);
        return (v == '0) ? v : v - word_t'(1);
    endfunction

    // Weakly-taken reset value: only the MSB set.
    function automatic word_t ctr_init(input int w);
        return word_t'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/gshare_branch_predictor_if.sv
// Fetch/resolution side of the predictor: request, response and update.
interface gshare_branch_predictor_if #(
    parameter int PC_WIDTH    = 32,
    parameter int GHR_WIDTH   = 10,
    parameter int INDEX_WIDTH = 10
);
    logic                   pred_req;
    logic [PC_WIDTH-1:0]    pred_pc;
    logic                   resp_valid;
    logic                   resp_taken;
    logic [INDEX_WIDTH-1:0] resp_index;
    logic [GHR_WIDTH-1:0]   resp_ghr;
    logic                   upd_valid;
    logic [INDEX_WIDTH-1:0] upd_index;
    logic [GHR_WIDTH-1:0]   upd_ghr;
    logic                   upd_taken;
    logic                   upd_mispredict;

    // Pipeline side: issues requests and updates, consumes responses.
    modport master (
        output pred_req, pred_pc,
        output upd_valid, upd_index, upd_ghr, upd_taken, upd_mispredict,
        input  resp_valid, resp_taken, resp_index, resp_ghr
    );

    // Predictor side.
    modport slave (
        input  pred_req, pred_pc,
        input  upd_valid, upd_index, upd_ghr, upd_taken, upd_mispredict,
        output resp_valid, resp_taken, resp_index, resp_ghr
    );
endinterface

// File: rtl/gshare_index_hash.sv
// Combinational gshare index: PC bits above PC_SHIFT XOR folded history.
module gshare_index_hash
    import bp_pkg::*;
#(
    parameter int PC_WIDTH    = 32,
    parameter int PC_SHIFT    = 2,
    parameter int GHR_WIDTH   = 10,
    parameter int INDEX_WIDTH = 10
) (
    input  logic [PC_WIDTH-1:0]    pc_i,
    input  logic [GHR_WIDTH-1:0]   ghr_i,
    output logic [INDEX_WIDTH-1:0] index_o
);
    logic [PC_WIDTH-1:0] pc_shifted;
    word_t               folded;
    logic                unused_bits;

    assign pc_shifted  = pc_i >> PC_SHIFT;
    assign folded      = fold(word_t'(ghr_i), GHR_WIDTH, INDEX_WIDTH);
    assign index_o     = pc_shifted[INDEX_WIDTH-1:0] ^ folded[INDEX_WIDTH-1:0];
    // High PC bits and the unused top of the fold word are intentionally dropped.
    assign unused_bits = ^{pc_shifted, folded};
endmodule

// File: rtl/gshare_branch_predictor.sv
// gshare direction predictor: counter table, speculative GHR with
// checkpoint-based repair, one-cycle registered response.
module gshare_branch_predictor
    import bp_pkg::*;
#(
    parameter int PC_WIDTH    = 32,
    parameter int PC_SHIFT    = 2,
    parameter int GHR_WIDTH   = 10,
    parameter int INDEX_WIDTH = 10,
    parameter int CTR_WIDTH   = 2
) (
    input  logic clk,
    input  logic rst_n,
    gshare_branch_predictor_if.slave bp
);
    localparam int DEPTH = 1 << INDEX_WIDTH;
    localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'(ctr_init(CTR_WIDTH));

    logic [CTR_WIDTH-1:0]   ctr_q [DEPTH];
    logic [CTR_WIDTH-1:0]   ctr_upd_cur;
    logic [CTR_WIDTH-1:0]   ctr_upd_d;
    logic [GHR_WIDTH-1:0]   spec_ghr_q, spec_ghr_d;
    logic [INDEX_WIDTH-1:0] pred_index;
    logic                   pred_taken;

    logic                   resp_valid_q, resp_valid_d;
    logic                   resp_taken_q, resp_taken_d;
    logic [INDEX_WIDTH-1:0] resp_index_q, resp_index_d;
    logic [GHR_WIDTH-1:0]   resp_ghr_q,   resp_ghr_d;
    logic                   unused_upd_ghr_msb;

    gshare_index_hash #(
        .PC_WIDTH    (PC_WIDTH),
        .PC_SHIFT    (PC_SHIFT),
        .GHR_WIDTH   (GHR_WIDTH),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_hash (
        .pc_i    (bp.pred_pc),
        .ghr_i   (spec_ghr_q),
        .index_o (pred_index)
    );

    // Prediction reads the pre-update counter; a same-cycle write lands at the edge.
    assign pred_taken  = ctr_q[pred_index][CTR_WIDTH-1];
    assign ctr_upd_cur = ctr_q[bp.upd_index];
    // Recovery shifts out the checkpoint's oldest bit, so it is never needed.
    assign unused_upd_ghr_msb = bp.upd_ghr[GHR_WIDTH-1];

    // Saturating counter step for the resolving branch.
    always_comb begin
        ctr_upd_d = ctr_upd_cur;
        if (bp.upd_taken) begin
            ctr_upd_d = CTR_WIDTH'(sat_inc(word_t'(ctr_upd_cur), CTR_WIDTH));
        end else begin
            ctr_upd_d = CTR_WIDTH'(sat_dec(word_t'(ctr_upd_cur)));
        end
    end

    // Counter table write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= CTR_INIT;
            end
        end else if (bp.upd_valid) begin
            ctr_q[bp.upd_index] <= ctr_upd_d;
        end
    end

    // History: speculative shift on predict; mispredict repair takes priority.
    always_comb begin
        spec_ghr_d = spec_ghr_q;
        if (bp.pred_req) begin
            spec_ghr_d = {spec_ghr_q[GHR_WIDTH-2:0], pred_taken};
        end
        if (bp.upd_valid && bp.upd_mispredict) begin
            spec_ghr_d = {bp.upd_ghr[GHR_WIDTH-2:0], bp.upd_taken};
        end
    end

    // Response capture; fields hold while no request is present.
    always_comb begin
        resp_valid_d = bp.pred_req;
        resp_taken_d = resp_taken_q;
        resp_index_d = resp_index_q;
        resp_ghr_d   = resp_ghr_q;
        if (bp.pred_req) begin
            resp_taken_d = pred_taken;
            resp_index_d = pred_index;
            resp_ghr_d   = spec_ghr_q;
        end
    end

    // History and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spec_ghr_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_taken_q <= 1'b0;
            resp_index_q <= '0;
            resp_ghr_q   <= '0;
        end else begin
            spec_ghr_q   <= spec_ghr_d;
            resp_valid_q <= resp_valid_d;
            resp_taken_q <= resp_taken_d;
            resp_index_q <= resp_index_d;
            resp_ghr_q   <= resp_ghr_d;
        end
    end

    assign bp.resp_valid = resp_valid_q;
    assign bp.resp_taken = resp_taken_q;
    assign bp.resp_index = resp_index_q;
    assign bp.resp_ghr   = resp_ghr_q;
endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Scoreboard bench for gshare_branch_predictor: stimulus pushes expected
// responses, a monitor pops and compares whenever resp_valid is seen.
module tb_gshare_branch_predictor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    typedef struct packed {
        logic       taken;
        logic [9:0] index;
        logic [9:0] ghr;
    } exp_t;
    exp_t exp_q [$];

    always #5 clk = ~clk;

    gshare_branch_predictor_if #(.PC_WIDTH(32), .GHR_WIDTH(10), .INDEX_WIDTH(10)) bp_if ();

    gshare_branch_predictor #(
        .PC_WIDTH(32), .PC_SHIFT(2), .GHR_WIDTH(10), .INDEX_WIDTH(10), .CTR_WIDTH(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp_if.slave)
    );

    // Separate hash instance at a wider GHR to exercise multi-chunk folding.
    logic [31:0] h_pc;
    logic [11:0] h_ghr;
    logic [9:0]  h_idx;
    gshare_index_hash #(.PC_WIDTH(32), .PC_SHIFT(2), .GHR_WIDTH(12), .INDEX_WIDTH(10)) u_hash12 (
        .pc_i    (h_pc),
        .ghr_i   (h_ghr),
        .index_o (h_idx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Drive one cycle of inputs at the falling edge.
    task automatic cyc(input logic req, input logic [31:0] pc,
                       input logic uv, input logic [9:0] ui, input logic [9:0] ug,
                       input logic ut, input logic um);
        @(negedge clk);
        bp_if.pred_req       = req;
        bp_if.pred_pc        = pc;
        bp_if.upd_valid      = uv;
        bp_if.upd_index      = ui;
        bp_if.upd_ghr        = ug;
        bp_if.upd_taken      = ut;
        bp_if.upd_mispredict = um;
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b0, 10'h0, 10'h0, 1'b0, 1'b0);
    endtask

    task automatic pred(input logic [31:0] pc, input logic t, input logic [9:0] i, input logic [9:0] g);
        cyc(1'b1, pc, 1'b0, 10'h0, 10'h0, 1'b0, 1'b0);
        exp_q.push_back('{taken: t, index: i, ghr: g});
    endtask

    task automatic upd(input logic [9:0] i, input logic t);
        cyc(1'b0, 32'h0, 1'b1, i, 10'h0, t, 1'b0);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: samples 2 time units after each rising edge.
    initial begin : monitor
        exp_t e;
        logic       prev_taken = 1'b0;
        logic [9:0] prev_index = '0;
        logic [9:0] prev_ghr   = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                prev_taken = 1'b0;
                prev_index = '0;
                prev_ghr   = '0;
            end else if (bp_if.resp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got index 0x%0h, expected no response", bp_if.resp_index);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_taken", 32'(bp_if.resp_taken), 32'(e.taken));
                    check("resp_index", 32'(bp_if.resp_index), 32'(e.index));
                    check("resp_ghr",   32'(bp_if.resp_ghr),   32'(e.ghr));
                    $display("resp taken=%0d index=0x%03h ghr=0x%03h", bp_if.resp_taken, bp_if.resp_index, bp_if.resp_ghr);
                end
                prev_taken = bp_if.resp_taken;
                prev_index = bp_if.resp_index;
                prev_ghr   = bp_if.resp_ghr;
            end else begin
                check("hold_taken", 32'(bp_if.resp_taken), 32'(prev_taken));
                check("hold_index", 32'(bp_if.resp_index), 32'(prev_index));
                check("hold_ghr",   32'(bp_if.resp_ghr),   32'(prev_ghr));
            end
        end
    end

    initial begin : stimulus
        bp_if.pred_req = 1'b0; bp_if.pred_pc = '0; bp_if.upd_valid = 1'b0;
        bp_if.upd_index = '0; bp_if.upd_ghr = '0; bp_if.upd_taken = 1'b0;
        bp_if.upd_mispredict = 1'b0;
        h_pc = '0; h_ghr = '0;
        do_reset();
        @(posedge clk); #2;
        check("reset_valid", 32'(bp_if.resp_valid), 32'h0);
        check("reset_taken", 32'(bp_if.resp_taken), 32'h0);
        check("reset_index", 32'(bp_if.resp_index), 32'h0);
        check("reset_ghr",   32'(bp_if.resp_ghr),   32'h0);

        // First prediction from reset: weakly taken at index 0.
        pred(32'h0000_1000, 1'b1, 10'h000, 10'h000);
        // spec_ghr is now 1: pc 0x1000 maps to index 1.
        pred(32'h0000_1000, 1'b1, 10'h001, 10'h001);
        idle();

        // Drive index 5 down to 0, predict not-taken, hold at 0.
        do_reset();
        upd(10'h005, 1'b0); upd(10'h005, 1'b0); upd(10'h005, 1'b0);
        pred(32'h0000_0014, 1'b0, 10'h005, 10'h000);
        upd(10'h005, 1'b0);
        pred(32'h0000_0014, 1'b0, 10'h005, 10'h000);
        // From 0, five taken updates saturate at 3 (a wrap would leave 1).
        repeat (5) upd(10'h005, 1'b1);
        pred(32'h0000_0014, 1'b1, 10'h005, 10'h000);
        // One not-taken from 3 gives 2, still taken. GHR is 1, so pc 0x10 -> index 5.
        upd(10'h005, 1'b0);
        pred(32'h0000_0010, 1'b1, 10'h005, 10'h001);
        idle();

        // Back-to-back predictions then recovery overriding a same-cycle shift.
        do_reset();
        pred(32'h0000_1000, 1'b1, 10'h000, 10'h000);
        pred(32'h0000_1000, 1'b1, 10'h001, 10'h001);
        cyc(1'b1, 32'h0000_1000, 1'b1, 10'h3FF, 10'h000, 1'b0, 1'b1);
        exp_q.push_back('{taken: 1'b1, index: 10'h003, ghr: 10'h003});
        pred(32'h0000_1000, 1'b1, 10'h000, 10'h000);
        // Recovery with upd_taken=1 from checkpoint 0x2 -> GHR 0x5.
        cyc(1'b0, 32'h0, 1'b1, 10'h3FE, 10'h202, 1'b1, 1'b1);
        pred(32'h0000_0000, 1'b1, 10'h005, 10'h005);
        idle();

        // Same-cycle predict and not-taken update to index 5.
        do_reset();
        cyc(1'b1, 32'h0000_0014, 1'b1, 10'h005, 10'h000, 1'b0, 1'b0);
        exp_q.push_back('{taken: 1'b1, index: 10'h005, ghr: 10'h000});
        pred(32'h0000_0010, 1'b0, 10'h005, 10'h001);
        idle();

        // Asynchronous reset while a response is pending.
        do_reset();
        upd(10'h005, 1'b0); upd(10'h005, 1'b0);
        upd(10'h000, 1'b1);
        pred(32'h0000_0000, 1'b1, 10'h000, 10'h000);
        cyc(1'b1, 32'h0000_0014, 1'b0, 10'h0, 10'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bp_if.pred_req = 1'b0;
        #1;
        check("async_reset_valid", 32'(bp_if.resp_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        pred(32'h0000_0014, 1'b1, 10'h005, 10'h000);
        pred(32'h0000_0004, 1'b1, 10'h000, 10'h001);
        idle();
        idle();

        // Multi-chunk fold: 0xC01 -> 0x001 ^ 0x003 = 0x002.
        h_pc = 32'h0000_0000; h_ghr = 12'hC01; #1;
        check("hash12_pc0", 32'(h_idx), 32'h002);
        h_pc = 32'h0000_0FFC; h_ghr = 12'hC01; #1;
        check("hash12_pc3ff", 32'(h_idx), 32'h3FD);
        h_pc = 32'h0000_0000; h_ghr = 12'h3FF; #1;
        check("hash12_lowchunk", 32'(h_idx), 32'h3FF);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gshare_branch_predictor.md
# gshare_branch_predictor

Parametrised gshare direction predictor, successor to the global-history-only predictor. It indexes a table of N-bit saturating counters with the fetch PC XOR-folded against a speculative global history register (GHR). Every prediction returns a checkpoint (index and GHR snapshot) so that resolution can update the correct entry and repair history on a mispredict. It sits between fetch, which issues requests, and branch resolution, which issues updates.

## Interface
- PC_WIDTH, 32, width of fetch PC
- PC_SHIFT, 2, low PC bits discarded before hashing
- GHR_WIDTH, 10, global history length; ≥2
- INDEX_WIDTH, 10, log2 of table depth; ≥2
- CTR_WIDTH, 2, saturating counter width; ≥1
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- pred_req  in  1  prediction request, sampled each cycle; no backpressure
- pred_pc  in  PC_WIDTH  branch PC
- resp_valid  out  1  response valid, one cycle after pred_req
- resp_taken  out  1  predicted direction (counter MSB)
- resp_index  out  INDEX_WIDTH  table index used (checkpoint)
- resp_ghr  out  GHR_WIDTH  speculative GHR before this prediction (checkpoint)
- upd_valid  in  1  resolution update
- upd_index  in  INDEX_WIDTH  index returned at prediction
- upd_ghr  in  GHR_WIDTH  GHR checkpoint returned at prediction
- upd_taken  in  1  actual direction
- upd_mispredict  in  1  repair history; qualified by upd_valid

## Operation
- Index: ((pred_pc >> PC_SHIFT) low INDEX_WIDTH bits) XOR fold(spec_ghr). fold XORs successive INDEX_WIDTH-bit chunks of the GHR, starting at the LSB; the last chunk is zero-extended.
- Prediction: on a pred_req cycle, compute the index, read the counter, and register resp_* for the next cycle. On the same edge, spec_ghr <= {spec_ghr[GHR_WIDTH-2:0], predicted_taken}.
- Update: when upd_valid is high, counter[upd_index] increments if upd_taken and decrements otherwise, saturating at 0 and 2^CTR_WIDTH−1. There is no wrap.
- Recovery: when upd_valid and upd_mispredict are both high, spec_ghr <= {upd_ghr[GHR_WIDTH-2:0], upd_taken}. This overrides any same-cycle speculative shift. That same-cycle prediction is still answered; it was computed with the pre-recovery GHR, and upstream discards it.
- Same-cycle prediction and update to the same index: the prediction reads the pre-update value, and the write takes effect at the edge.
- No update without upd_mispredict alters spec_ghr.
- Reset values: every counter = 2^(CTR_WIDTH−1) (weakly taken); spec_ghr = 0; resp_valid, resp_taken, resp_index and resp_ghr = 0.

## Timing
- Prediction latency: exactly 1 cycle from pred_req to resp_valid. Requests can arrive back-to-back at 1 per cycle, and each sees the GHR shifted by all prior predictions.
- resp_valid is high for exactly 1 cycle per request. resp_* hold their previous values while resp_valid is low.
- Update write and recovery are visible to a pred_req in the following cycle.
- Reset mid-operation: assertion of rst_n clears a pending response immediately (asynchronously), with no response delivered. The first request is accepted on the first edge after deassertion.

## Structure
- Shared package bp_pkg holds:
  - the fold function (GHR to INDEX_WIDTH), parametrised via a function with width arguments
  - saturating increment/decrement helpers
  - the CTR_INIT constant expression
- Sub-module gshare_index_hash is purely combinational: pc and ghr in, index out, using PC_SHIFT, GHR_WIDTH and INDEX_WIDTH. It is reused by the future tournament predictor.
- The top level holds the counter array, spec_ghr and the response registers.

## Test plan
- Reset, then pred_req with pred_pc=0x0000_1000 gives index 0x000. Next cycle: resp_valid=1, resp_taken=1, resp_index=0x000, resp_ghr=0x000. spec_ghr becomes 0x001.
- Reset, then 3 updates (upd_index=0x005, upd_taken=0), then pred_req with pred_pc=0x0000_0014 gives resp_index=0x005 and resp_taken=0. The counter holds at 0 after a 4th not-taken update.
- From counter 0 at index 0x005, 5 taken updates bring the counter to 3 and keep it there. A prediction then gives resp_taken=1.
- Two back-to-back taken predictions move spec_ghr to 0x003. Then, in one cycle, drive upd_valid=1, upd_mispredict=1, upd_ghr=0x000, upd_taken=0 together with pred_req. Required: the response carries resp_ghr=0x003, and spec_ghr becomes 0x000 (the shift is overridden).
- Same cycle: pred_req hitting index 0x005 (counter=2) and a not-taken update to 0x005. Required: resp_taken=1, then the following prediction gives 0.
- Assert rst_n low mid-cycle while a response is pending. Required: resp_valid=0 asynchronously, all counters read 2, and spec_ghr=0.
- With GHR_WIDTH=12 and INDEX_WIDTH=10, spec_ghr=0xC01 and pc index bits 0x000 give index 0x001 XOR 0x003 = 0x002.
